// File: rtl/adsr_env_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adsr_pkg
// Brief    : Shared phase encoding, phase width and peak level for the ADSR
//            envelope slice, plus the 2-input 4-bit mux used for rate select.
// Revision : 1.0
// ============================================================================
package adsr_pkg;

    localparam int unsigned PHASE_W = 3;

    localparam logic [PHASE_W-1:0] IDLE    = 3'd0;
    localparam logic [PHASE_W-1:0] ATTACK  = 3'd1;
    localparam logic [PHASE_W-1:0] DECAY   = 3'd2;
    localparam logic [PHASE_W-1:0] SUSTAIN = 3'd3;
    localparam logic [PHASE_W-1:0] RELEASE = 3'd4;

    localparam int unsigned ENV_MAX = 15;

    function automatic logic [3:0] mux2_4(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       sel);
        return sel ? b : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_env_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adsr_env_ctrl_if
// Brief    : Key-gate / rate controls in, envelope level and phase out.
// Revision : 1.0
// ============================================================================
interface adsr_env_ctrl_if #(
    parameter int unsigned ENV_W = 4
) ();
    logic             tick;
    logic             gate;
    logic [ENV_W-1:0] attack_rate;
    logic [ENV_W-1:0] decay_rate;
    logic [ENV_W-1:0] sustain_level;
    logic [ENV_W-1:0] release_rate;
    logic [ENV_W-1:0] env;
    logic [2:0]       phase;
    logic             busy;

    modport master (
        output tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        input  env, phase, busy
    );

    modport slave (
        input  tick, gate, attack_rate, decay_rate, sustain_level, release_rate,
        output env, phase, busy
    );
endinterface
`default_nettype wire

// File: rtl/adsr_env_ctrl_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : adsr_tick_div
// Brief    : Tick prescaler; emits one step every rate+1 ticks unless cleared.
// Revision : 1.0
// ============================================================================
module adsr_tick_div #(
    parameter int unsigned ENV_W = 4
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire             tick_i,
    input  wire [ENV_W-1:0] rate_i,
    input  wire             clr_i,
    output logic            step_o
);

    logic [ENV_W-1:0] cnt_q;
    logic [ENV_W-1:0] cnt_d;
    logic             w_hit;

    assign w_hit = (cnt_q == rate_i);

    // A rate lowered below cnt keeps counting and wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = w_hit ? '0 : cnt_q + ENV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_o = tick_i & ~clr_i & w_hit;

endmodule
`default_nettype wire

// File: rtl/adsr_env_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adsr_env_ctrl
// Brief    : One-voice ADSR phase machine producing a saturating envelope level.
// Revision : 1.0
// ============================================================================
module adsr_env_ctrl #(
    parameter int unsigned ENV_W   = 4,
    parameter int unsigned ENV_MAX = adsr_pkg::ENV_MAX
) (
    input  wire             clk,
    input  wire             rst_n,
    adsr_env_ctrl_if.slave  bus
);
    import adsr_pkg::*;

    localparam logic [ENV_W-1:0] c_ENV_MAX = ENV_W'(ENV_MAX);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [ENV_W-1:0]   env_q;
    logic [ENV_W-1:0]   env_d;
    logic               gate_q;

    logic               w_rise;
    logic               w_phase_chg;
    logic               w_clr;
    logic               w_step;
    logic [ENV_W-1:0]   w_rate_ad;
    logic [ENV_W-1:0]   w_rate;

    assign w_rise = bus.gate & ~gate_q;

    assign w_rate_ad = mux2_4(bus.attack_rate, bus.decay_rate,   phase_q == DECAY);
    assign w_rate    = mux2_4(w_rate_ad,       bus.release_rate, phase_q == RELEASE);

    // A tick landing on a phase change is absorbed by the clear.
    assign w_phase_chg = (phase_d != phase_q);
    assign w_clr       = w_phase_chg | (phase_q == IDLE) | (phase_q == SUSTAIN);

    adsr_tick_div #(
        .ENV_W (ENV_W)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_i (bus.tick),
        .rate_i (w_rate),
        .clr_i  (w_clr),
        .step_o (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE;
            env_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            env_q   <= env_d;
            gate_q  <= bus.gate;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (!bus.gate && (phase_q == ATTACK || phase_q == DECAY || phase_q == SUSTAIN)) begin
            phase_d = RELEASE;
        end else if (w_rise && phase_q != ATTACK) begin
            phase_d = ATTACK;
        end else begin
            case (phase_q)
                IDLE:    phase_d = IDLE;
                ATTACK:  if (env_q == c_ENV_MAX)         phase_d = DECAY;
                DECAY:   if (env_q <= bus.sustain_level) phase_d = SUSTAIN;
                SUSTAIN: phase_d = SUSTAIN;
                RELEASE: if (env_q == '0)                phase_d = IDLE;
                default: phase_d = IDLE;
            endcase
        end
    end

    // env only moves while the phase is stable; transitions hold the level.
    always_comb begin
        env_d = env_q;
        if (!w_phase_chg) begin
            case (phase_q)
                IDLE:    env_d = '0;
                ATTACK:  if (w_step && env_q != c_ENV_MAX) env_d = env_q + ENV_W'(1);
                DECAY,
                RELEASE: if (w_step && env_q != '0)        env_d = env_q - ENV_W'(1);
                default: env_d = env_q;
            endcase
        end
    end

    always_comb begin
        bus.env   = env_q;
        bus.phase = phase_q;
        bus.busy  = (phase_q != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_adsr_env_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adsr_env_ctrl
// Brief    : Directed scoreboard bench for the ADSR envelope controller.
// Revision : 1.0
// ============================================================================
module tb_adsr_env_ctrl;

    typedef struct {
        string      tag;
        logic [3:0] env;
        logic [2:0] ph;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    adsr_env_ctrl_if #(.ENV_W(4)) bus ();

    adsr_env_ctrl #(
        .ENV_W   (4),
        .ENV_MAX (15)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_now(input string tag, input logic [3:0] e, input logic [2:0] p);
        exp_t x;
        x.tag = tag;
        x.env = e;
        x.ph  = p;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        logic exp_busy;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: observed empty queue, required an entry");
            return;
        end
        x = sb.pop_front();
        exp_busy = (x.ph != 3'd0);
        n_tests += 3;
        assert (bus.env === x.env) else begin
            n_fail++;
            $error("FAIL %s env: observed %0d expected %0d", x.tag, bus.env, x.env);
        end
        assert (bus.phase === x.ph) else begin
            n_fail++;
            $error("FAIL %s phase: observed %0d expected %0d", x.tag, bus.phase, x.ph);
        end
        assert (bus.busy === exp_busy) else begin
            n_fail++;
            $error("FAIL %s busy: observed %0b expected %0b", x.tag, bus.busy, exp_busy);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input string tag, input int n, input logic [3:0] e, input logic [2:0] p);
        expect_now(tag, e, p);
        cyc(n);
        check_out();
    endtask

    task automatic wait_phase(input string tag, input logic [2:0] p, input logic [3:0] e,
                              input int budget);
        expect_now(tag, e, p);
        for (int i = 0; i < budget && bus.phase !== p; i++) cyc(1);
        check_out();
    endtask

    task automatic spaced_ticks(input int k);
        repeat (k) begin
            bus.tick = 1'b1;
            cyc(1);
            bus.tick = 1'b0;
            cyc(4);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n              = 1'b0;
        bus.tick           = 1'b0;
        bus.gate           = 1'b0;
        bus.attack_rate    = 4'd0;
        bus.decay_rate     = 4'd0;
        bus.sustain_level  = 4'd8;
        bus.release_rate   = 4'd0;

        cyc(2);
        step("reset", 0, 4'd0, 3'd0);
        rst_n = 1'b1;
        step("idle_hold", 5, 4'd0, 3'd0);

        // Full envelope, every rate 0, tick every cycle.
        bus.tick = 1'b1;
        bus.gate = 1'b1;
        step("att_entry",   1, 4'd0,  3'd1);
        step("att_mid",     7, 4'd7,  3'd1);
        step("att_peak",    8, 4'd15, 3'd1);
        step("dec_entry",   1, 4'd15, 3'd2);
        step("dec_end",     7, 4'd8,  3'd2);
        step("sus_entry",   1, 4'd8,  3'd3);
        step("sus_hold",    4, 4'd8,  3'd3);
        bus.gate = 1'b0;
        step("rel_entry",   1, 4'd8,  3'd4);
        step("rel_end",     8, 4'd0,  3'd4);
        step("idle_back",   1, 4'd0,  3'd0);

        // Prescaler: rate 3, then ticks spaced 5 clocks apart.
        bus.attack_rate = 4'd3;
        bus.gate = 1'b1;
        step("pre_entry",   1, 4'd0, 3'd1);
        step("pre_1",       4, 4'd1, 3'd1);
        step("pre_1hold",   3, 4'd1, 3'd1);
        step("pre_2",       1, 4'd2, 3'd1);
        expect_now("pre_sp3", 4'd2, 3'd1);
        spaced_ticks(3);
        check_out();
        expect_now("pre_sp4", 4'd3, 3'd1);
        spaced_ticks(1);
        check_out();
        bus.attack_rate = 4'd0;
        bus.tick = 1'b1;
        bus.gate = 1'b0;
        step("pre_rel", 1, 4'd3, 3'd4);
        wait_phase("pre_idle", 3'd0, 4'd0, 40);

        // Retrigger out of RELEASE continues from the current level.
        bus.gate = 1'b1;
        step("rt_entry", 1, 4'd0, 3'd1);
        wait_phase("rt_sus", 3'd3, 4'd8, 60);
        bus.gate = 1'b0;
        step("rt_rel",   1, 4'd8, 3'd4);
        step("rt_rel5",  3, 4'd5, 3'd4);
        bus.gate = 1'b1;
        step("rt_att",   1, 4'd5, 3'd1);
        step("rt_6",     1, 4'd6, 3'd1);
        step("rt_7",     1, 4'd7, 3'd1);
        bus.gate = 1'b0;
        step("rt_off",   1, 4'd7, 3'd4);
        wait_phase("rt_idle", 3'd0, 4'd0, 40);

        // Gate falls in ATTACK on a step cycle: the step is dropped.
        bus.gate = 1'b1;
        step("er_entry", 1, 4'd0, 3'd1);
        step("er_6",     6, 4'd6, 3'd1);
        bus.gate = 1'b0;
        step("er_rel",   1, 4'd6, 3'd4);
        step("er_next",  1, 4'd5, 3'd4);
        wait_phase("er_idle", 3'd0, 4'd0, 40);

        // sustain_level = 15: one DECAY cycle, then SUSTAIN at the peak.
        bus.sustain_level = 4'd15;
        bus.gate = 1'b1;
        step("s15_entry", 1,  4'd0,  3'd1);
        step("s15_peak",  15, 4'd15, 3'd1);
        step("s15_dec",   1,  4'd15, 3'd2);
        step("s15_sus",   1,  4'd15, 3'd3);
        step("s15_hold",  5,  4'd15, 3'd3);
        bus.gate = 1'b0;
        wait_phase("s15_idle", 3'd0, 4'd0, 40);

        // sustain_level = 0: SUSTAIN at 0, not IDLE, while gate held.
        bus.sustain_level = 4'd0;
        bus.gate = 1'b1;
        step("s0_entry",  1,  4'd0,  3'd1);
        step("s0_peak",   15, 4'd15, 3'd1);
        step("s0_dec",    1,  4'd15, 3'd2);
        step("s0_decend", 15, 4'd0,  3'd2);
        step("s0_sus",    1,  4'd0,  3'd3);
        step("s0_hold",   5,  4'd0,  3'd3);
        bus.gate = 1'b0;
        step("s0_rel",    1,  4'd0,  3'd4);
        step("s0_idle",   1,  4'd0,  3'd0);

        // Asynchronous reset mid-ATTACK, then a held gate retriggers.
        bus.sustain_level = 4'd8;
        bus.gate = 1'b1;
        step("ar_entry", 1, 4'd0, 3'd1);
        step("ar_7",     7, 4'd7, 3'd1);
        expect_now("ar_async", 4'd0, 3'd0);
        #3 rst_n = 1'b0;
        #1 check_out();
        #1 rst_n = 1'b1;
        step("ar_rise",  1, 4'd0, 3'd1);
        step("ar_climb", 1, 4'd1, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adsr_env_ctrl.md
Name: adsr_env_ctrl

Overview:
Sequences one voice's ADSR envelope. The block is a phase state machine plus a tick prescaler that produces a 4-bit envelope level. It picks the active per-phase rate: attack, decay or release. It sits between the key-gate logic and the amplitude multiplier, and runs once per sample tick.

Parameters:
- ENV_W, 4, envelope and rate/level width in bits.
- ENV_MAX, 15, peak level reached at the end of attack (2^ENV_W-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle sample-rate enable; envelope steps only on tick.
- gate  in  1  key held (synchronous to clk).
- attack_rate  in  ENV_W  ticks per attack step, minus 1.
- decay_rate  in  ENV_W  ticks per decay step, minus 1.
- sustain_level  in  ENV_W  hold level during sustain.
- release_rate  in  ENV_W  ticks per release step, minus 1.
- env  out  ENV_W  registered envelope level.
- phase  out  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  phase != IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: env=0, phase=IDLE, busy=0, prescale count=0, gate_q=0.
- Gate edges: gate_q is a registered copy of gate. rise = gate & ~gate_q. A gate held high out of reset produces a rise on the first cycle after release.
- Active rate: ATTACK uses attack_rate, DECAY uses decay_rate, RELEASE uses release_rate. IDLE and SUSTAIN have no rate and the prescaler is held at 0.
- Prescaler, in ATTACK, DECAY and RELEASE:
  - On tick with cnt == rate: cnt<=0 and step env.
  - On tick otherwise: cnt++.
  - Without tick: hold.
  - cnt clears to 0 on every phase change.
- One step = one change in env. Rate r gives one step per r+1 ticks. The step is visible on env the cycle after the qualifying tick.
- Transitions are evaluated every clk, not only on tick. Priority, highest first:
  1. gate==0 and phase in {ATTACK, DECAY, SUSTAIN} -> RELEASE. env is held on this cycle.
  2. rise in any phase other than ATTACK -> ATTACK. env is kept, not zeroed, so a retrigger from RELEASE or SUSTAIN ramps up from the current level.
  3. ATTACK:
     - env==ENV_MAX -> DECAY.
     - Otherwise env++ on each step.
  4. DECAY:
     - env<=sustain_level -> SUSTAIN.
     - Otherwise env-- on each step.
     - sustain_level>=ENV_MAX gives DECAY for one cycle, then SUSTAIN.
  5. SUSTAIN: env holds. A later change of sustain_level is not tracked until the next note.
  6. RELEASE:
     - env==0 -> IDLE.
     - Otherwise env-- on each step.
  7. IDLE: env=0; wait for rise.
- Arithmetic: env never wraps. Increment saturates at ENV_MAX and decrement saturates at 0, even if inputs change mid-phase.
- Rates are sampled live. A rate change mid-phase takes effect at the next compare. If the new rate is below cnt, stepping resumes only after cnt wraps through 2^ENV_W.
- Simultaneous events:
  - gate falling on the same cycle as an ATTACK step: RELEASE wins and the step is dropped.
  - tick coinciding with a phase change: the tick is consumed by the transition, not counted.
- Reset mid-note: immediate return to IDLE, env=0.

Decomposition:
- Shared package adsr_pkg holds the phase encoding constants (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), the phase width (3) and ENV_MAX.
- One sub-module, adsr_tick_div. It contains the prescale counter with inputs tick, rate, clr and output step.
- The rate selection is a 3:1 choose driven by phase and stays inline in adsr_env_ctrl. It reuses the team's 2-input 4-bit mux, cascaded twice.

Test Plan:
- Reset/idle: assert rst_n=0 mid-ATTACK with env=7 -> env=0, phase=0, busy=0 asynchronously, without waiting for a clk edge. With rst_n=1 and gate=0, the block stays IDLE.
- Full envelope: tick every cycle, all rates=0, sustain_level=8, gate high.
  - Attack: env reaches 15 after 15 ticks, then phase=2.
  - Decay: env reaches 8 after 7 more ticks, then phase=3.
  - Release: drop gate -> phase=4; env reaches 0 after 8 ticks, then phase=0, busy=0.
- Prescaler: attack_rate=3 -> env increments exactly once every 4 ticks. Ticks spaced 5 clks apart never change the step count.
- Retrigger: gate low in RELEASE at env=5, then gate high -> phase=1 with env continuing 5,6,7… There is no dip to 0.
- Early release: gate falls in ATTACK at env=6 on the same cycle as a step -> phase=4 and env stays 6, not 7.
- Boundary:
  - sustain_level=15 -> DECAY lasts one cycle, SUSTAIN holds at 15.
  - sustain_level=0 -> decay to 0, phase=3 (not IDLE) while gate stays high.
